ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 92 +++++++++
 tb/tb_ram_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter between core and loader, sequencing one RAM access per 3 cycles
module ram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_done,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] ram_opcode,
  output logic [DATA_WIDTH-1:0] ram_operand,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  ram_read_enable,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic last_grant, win_id, pick, any_req, we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [7:0] a8;
  assign any_req = req0_valid | req1_valid;
  // on contention the requester that did not win last time goes first
  assign pick = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign a8 = 8'(addr_q);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    req0_done = 1'b0;
    req1_done = 1'b0;
    ram_opcode = '0;
    ram_operand = '0;
    ram_write_data = '0;
    ram_read_enable = 1'b0;
    ram_write_enable = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req && !reset) begin
          state_n = ACCESS;
          req0_ready = ~pick;
          req1_ready = pick;
        end
      end
      ACCESS: begin
        state_n = DONE;
        ram_opcode = we_q ? DATA_WIDTH'({8'h31, a8}) : DATA_WIDTH'(16'h4200);
        ram_operand = we_q ? '0 : DATA_WIDTH'(a8);
        ram_write_data = we_q ? wdata_q : '0;
        ram_write_enable = we_q;
        ram_read_enable = ~we_q;
      end
      DONE: begin
        state_n = IDLE;
        req0_done = ~win_id;
        req1_done = win_id;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      rdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        last_grant <= pick;
        win_id <= pick;
        we_q <= pick ? req1_we : req0_we;
        addr_q <= pick ? req1_addr : req0_addr;
        wdata_q <= pick ? req1_wdata : req0_wdata;
      end
      if (state == ACCESS && !we_q) rdata <= ram_read_data;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter against a transaction-level model
module tb_ram_arbiter;
  logic clk = 0, rst = 1;
  logic v0 = 0, we0 = 0, v1 = 0, we1 = 0;
  logic [7:0] a0 = 0, a1 = 0;
  logic [15:0] d0 = 0, d1 = 0;
  logic req0_ready, req0_done, req1_ready, req1_done, ram_read_enable, ram_write_enable, busy;
  logic [15:0] rdata, ram_opcode, ram_operand, ram_write_data, ram_read_data;
  logic [15:0] mem [256];
  logic [15:0] mm [256];
  int checks = 0, errors = 0;
  bit started = 0;
  int m_age = 0;
  logic m_last = 1, t_id = 0, t_we = 0;
  logic [7:0] t_a = 0;
  logic [15:0] t_d = 0, m_rdata = 0;
  logic rs0, rs1;

  ram_arbiter dut (
    .clk(clk), .reset(rst),
    .req0_valid(v0), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(v1), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .rdata(rdata), .ram_opcode(ram_opcode), .ram_operand(ram_operand),
    .ram_write_data(ram_write_data), .ram_read_enable(ram_read_enable),
    .ram_write_enable(ram_write_enable), .ram_read_data(ram_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) begin
    mem[i] = 0;
    mm[i] = 0;
  end
  assign ram_read_data = mem[ram_operand[7:0]];
  always @(posedge clk) if (ram_write_enable === 1'b1) mem[ram_opcode[7:0]] <= ram_write_data;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic winner(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return last == 1'b1 ? 1'b0 : 1'b1;
    return r0 ? 1'b0 : 1'b1;
  endfunction

  // model: a transaction is accepted in an idle cycle, touches the RAM one cycle later, completes the cycle after
  always @(posedge clk) begin
    if (rst) begin
      if (m_age == 1 && t_we) mm[t_a] <= t_d;
      started <= 1;
      m_age <= 0;
      m_last <= 1;
      m_rdata <= 0;
    end else if (started) begin
      if (m_age == 0 && (v0 || v1)) begin
        t_id <= winner(v0, v1, m_last);
        m_last <= winner(v0, v1, m_last);
        t_we <= winner(v0, v1, m_last) ? we1 : we0;
        t_a <= winner(v0, v1, m_last) ? a1 : a0;
        t_d <= winner(v0, v1, m_last) ? d1 : d0;
        m_age <= 1;
      end else if (m_age == 1) begin
        if (t_we) mm[t_a] <= t_d;
        else m_rdata <= mm[t_a];
        m_age <= 2;
      end else if (m_age == 2) m_age <= 0;
    end
  end

  always @(negedge clk) if (started) begin
    logic idle, acc, dn, g;
    idle = m_age == 0;
    acc = m_age == 1;
    dn = m_age == 2;
    g = winner(v0, v1, m_last);
    chk("req0_ready", req0_ready, idle && !rst && v0 && g == 1'b0);
    chk("req1_ready", req1_ready, idle && !rst && v1 && g == 1'b1);
    chk("req0_done", req0_done, dn && t_id == 1'b0);
    chk("req1_done", req1_done, dn && t_id == 1'b1);
    chk("busy", busy, !idle);
    chk("rdata", rdata, m_rdata);
    chk("ram_opcode", ram_opcode, !acc ? 16'h0 : t_we ? {8'h31, t_a} : 16'h4200);
    chk("ram_operand", ram_operand, (acc && !t_we) ? {8'h00, t_a} : 16'h0);
    chk("ram_write_data", ram_write_data, (acc && t_we) ? t_d : 16'h0);
    chk("ram_write_enable", ram_write_enable, acc && t_we);
    chk("ram_read_enable", ram_read_enable, acc && !t_we);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    v0 = 0;
    v1 = 0;
    cyc();
    cyc();
    rst = 0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rdata", rdata, 0);
    cyc();
    v0 = 1; we0 = 1; a0 = 8'h05; d0 = 16'hBEEF;
    @(negedge clk);
    chk("wr_ready0", req0_ready, 1);
    chk("wr_ready1", req1_ready, 0);
    cyc();
    v0 = 0;
    @(negedge clk);
    chk("wr_opcode", ram_opcode, 16'h3105);
    chk("wr_wdata", ram_write_data, 16'hBEEF);
    chk("wr_we", ram_write_enable, 1);
    chk("wr_busy1", busy, 1);
    cyc();
    @(negedge clk);
    chk("wr_done0", req0_done, 1);
    chk("wr_busy2", busy, 1);
    cyc();
    @(negedge clk);
    chk("wr_idle", busy, 0);
    cyc();
    v1 = 1; we1 = 0; a1 = 8'h05;
    @(negedge clk);
    chk("rd_ready1", req1_ready, 1);
    cyc();
    v1 = 0;
    @(negedge clk);
    chk("rd_opcode", ram_opcode, 16'h4200);
    chk("rd_operand", ram_operand, 16'h0005);
    chk("rd_re", ram_read_enable, 1);
    cyc();
    @(negedge clk);
    chk("rd_done1", req1_done, 1);
    chk("rd_rdata", rdata, 16'hBEEF);
    do_reset();
    v0 = 1; we0 = 0; a0 = 8'h01; v1 = 1; we1 = 0; a1 = 8'h02;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("rr_ready0", req0_ready, c % 6 == 0);
      chk("rr_ready1", req1_ready, c % 6 == 3);
      cyc();
    end
    do_reset();
    v0 = 1; we0 = 1; a0 = 8'h10; d0 = 16'h1234;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("b2b_ready0", req0_ready, c % 3 == 0);
      cyc();
    end
    v0 = 0;
    cyc();
    cyc();
    v0 = 1; we0 = 0; a0 = 8'h10;
    cyc();
    v0 = 0;
    rst = 1;
    @(negedge clk);
    chk("abort_re_before", ram_read_enable, 1);
    cyc();
    rst = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_re", ram_read_enable, 0);
    chk("abort_we", ram_write_enable, 0);
    chk("abort_done", req0_done, 0);
    chk("abort_rdata", rdata, 16'h0000);
    cyc();
    @(negedge clk);
    chk("abort_done_late", req0_done, 0);
    cyc();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("quiet_opcode", ram_opcode, 0);
      chk("quiet_en", {ram_read_enable, ram_write_enable}, 0);
      chk("quiet_busy", busy, 0);
      cyc();
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rs0 = req0_ready;
      rs1 = req1_ready;
      cyc();
      if (!v0 || rs0) begin
        v0 = $urandom_range(0, 2) != 0;
        we0 = 1'($urandom);
        a0 = 8'($urandom_range(0, 15));
        d0 = 16'($urandom);
      end
      if (!v1 || rs1) begin
        v1 = $urandom_range(0, 2) != 0;
        we1 = 1'($urandom);
        a1 = 8'($urandom_range(0, 15));
        d1 = 16'($urandom);
      end
      rst = $urandom_range(0, 199) == 0;
    end
    rst = 0;
    v0 = 0;
    v1 = 0;
    cyc();
    cyc();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
